// File: rtl/gig_eth_mac_pkg.sv
// Shared types for the GbE MAC receive frame buffer.
// Write-side FSM encoding and RAM word width.
package gig_eth_mac_pkg;

  localparam int RAM_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/gig_eth_mac_rx_fifo_ram.sv
// Simple dual-port frame RAM, one write port and one
// synchronous read port; read data holds when re is low.
module gig_eth_mac_rx_fifo_ram
  import gig_eth_mac_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [RAM_W-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [RAM_W-1:0]      rdata
);

  logic [RAM_W-1:0] mem [2**ADDR_WIDTH];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/gig_eth_mac_rx_frame_fifo.sv
// Store-and-forward RX frame buffer: frames become visible
// to the reader only after goodframe commits them.
module gig_eth_mac_rx_frame_fifo
  import gig_eth_mac_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic [7:0]  mac_rx_data,
  input  logic        mac_rx_dvld,
  input  logic        mac_rx_goodframe,
  input  logic        mac_rx_badframe,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eof,
  output logic [15:0] stat_good,
  output logic [15:0] stat_drop_bad,
  output logic [15:0] stat_drop_ovf
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2**ADDR_WIDTH);
  localparam logic [PW-1:0] ONE = PW'(1);

  wr_state_t       state, state_n;
  logic [PW-1:0]   wr_ptr, wr_ptr_n;
  logic [PW-1:0]   commit_ptr, commit_n;
  logic [PW-1:0]   frame_base, base_n;
  logic [PW-1:0]   rd_ptr, used;
  logic [7:0]      hold_reg, hold_n;
  logic            space, we;
  logic [RAM_W-1:0] wdata, ram_q;
  logic            inc_good, inc_bad, inc_ovf;
  logic            rd_en, vld_r, sof_flag;

  assign used  = wr_ptr - rd_ptr;
  assign space = (used != DEPTH);

  // Write FSM state register
  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Write FSM next state, RAM write and pointer updates
  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    commit_n = commit_ptr;
    base_n   = frame_base;
    hold_n   = hold_reg;
    we       = 1'b0;
    wdata    = {1'b0, hold_reg};
    inc_good = 1'b0;
    inc_bad  = 1'b0;
    inc_ovf  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (mac_rx_dvld) begin
          hold_n  = mac_rx_data;
          base_n  = commit_ptr;
          state_n = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mac_rx_badframe) begin
          wr_ptr_n = frame_base;
          inc_bad  = 1'b1;
          state_n  = ST_IDLE;
        end else if (mac_rx_goodframe) begin
          if (space) begin
            we       = 1'b1;
            wdata    = {1'b1, hold_reg};
            wr_ptr_n = wr_ptr + ONE;
            commit_n = wr_ptr + ONE;
            inc_good = 1'b1;
          end else begin
            wr_ptr_n = frame_base;
            inc_ovf  = 1'b1;
          end
          state_n = ST_IDLE;
        end else if (mac_rx_dvld) begin
          if (space) begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + ONE;
            hold_n   = mac_rx_data;
          end else begin
            wr_ptr_n = frame_base;
            state_n  = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (mac_rx_goodframe || mac_rx_badframe) begin
          inc_ovf = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Write-side pointers, hold register and statistics
  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      frame_base    <= '0;
      hold_reg      <= '0;
      stat_good     <= '0;
      stat_drop_bad <= '0;
      stat_drop_ovf <= '0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_n;
      frame_base <= base_n;
      hold_reg   <= hold_n;
      if (inc_good) stat_good <= stat_good + 16'd1;
      if (inc_bad)  stat_drop_bad <= stat_drop_bad + 16'd1;
      if (inc_ovf)  stat_drop_ovf <= stat_drop_ovf + 16'd1;
    end
  end

  // Fetch the next committed byte whenever the output slot frees
  assign rd_en = (rd_ptr != commit_ptr) && (!vld_r || out_ready);

  // Read pointer, output valid and start-of-frame tracking
  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      vld_r    <= 1'b0;
      sof_flag <= 1'b1;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + ONE;
      if (rd_en)          vld_r <= 1'b1;
      else if (out_ready) vld_r <= 1'b0;
      if (vld_r && out_ready) sof_flag <= ram_q[RAM_W-1];
    end
  end

  gig_eth_mac_rx_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (rx_clk),
    .we    (we),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (ram_q)
  );

  assign out_valid = vld_r;
  assign out_data  = vld_r ? ram_q[7:0] : 8'h00;
  assign out_eof   = vld_r & ram_q[RAM_W-1];
  assign out_sof   = vld_r & sof_flag;

endmodule
